// File: rtl/bloom_mask_writer.sv
// Programming side of the packet Bloom filter: sets four mask bits per insert, one per
// cycle, and clears the 512-bit mask one 32-bit word per cycle. Define BLOOM_WR_POPCOUNT_EN for pop_cnt.
module bloom_mask_writer (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [8:0]   idx0,
    input  logic [8:0]   idx1,
    input  logic [8:0]   idx2,
    input  logic [8:0]   idx3,
    input  logic         clr_req,
    output logic [511:0] mask,
    output logic         busy,
    output logic         done,
    output logic [15:0]  insert_cnt,
    output logic [9:0]   pop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SET,
        CLEAR,
        DONE
    } state_t;

    state_t     state;
    logic [8:0] idx_q [4];
    logic [1:0] k;
    logic [3:0] w;
    logic [8:0] cur_idx;

    always_comb begin
        in_ready = (state == IDLE);
        cur_idx  = idx_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mask       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            insert_cnt <= '0;
            k          <= '0;
            w          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // Clear wins over a simultaneous insert; that insert is dropped.
                    if (clr_req) begin
                        state <= CLEAR;
                        w     <= '0;
                        busy  <= 1'b1;
                    end else if (in_valid) begin
                        idx_q[0] <= idx0;
                        idx_q[1] <= idx1;
                        idx_q[2] <= idx2;
                        idx_q[3] <= idx3;
                        k        <= '0;
                        state    <= SET;
                        busy     <= 1'b1;
                    end
                end
                SET: begin
                    mask[cur_idx] <= 1'b1;
                    k             <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (insert_cnt != 16'hFFFF) begin
                            insert_cnt <= insert_cnt + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    mask[{w, 5'd0} +: 32] <= '0;
                    w                     <= w + 4'd1;
                    if (w == 4'd15) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        insert_cnt <= '0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLOOM_WR_POPCOUNT_EN
    // Counts only 0->1 transitions, so duplicates within or across inserts count once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt <= '0;
        end else if (state == SET && !mask[cur_idx]) begin
            pop_cnt <= pop_cnt + 10'd1;
        end else if (state == CLEAR && w == 4'd15) begin
            pop_cnt <= '0;
        end
    end
`else
    always_comb begin
        pop_cnt = '0;
    end
`endif

endmodule
